// File: rtl/stage_if_bpred_if.sv
// Fetch-stage bundle: instruction load, ID-side control and BHT update (slave side)
// and the registered IF/ID output (master side).
interface stage_if_bpred_if;
  logic        imem_wren;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        jump;
  logic [31:0] jump_addr;
  logic        bht_upd;
  logic [31:0] bht_upd_pc;
  logic        bht_upd_taken;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;
  logic [31:0] if_inst;
  logic [31:0] if_branch_addr;
  logic        if_ctrl_branch;
  logic        if_pred_taken;

  modport master (
    input  imem_wren, imem_waddr, imem_wdata, stall, redirect, redirect_addr,
           jump, jump_addr, bht_upd, bht_upd_pc, bht_upd_taken,
    output if_valid, if_pc, if_pc_4, if_inst, if_branch_addr, if_ctrl_branch, if_pred_taken
  );

  modport slave (
    output imem_wren, imem_waddr, imem_wdata, stall, redirect, redirect_addr,
           jump, jump_addr, bht_upd, bht_upd_pc, bht_upd_taken,
    input  if_valid, if_pc, if_pc_4, if_inst, if_branch_addr, if_ctrl_branch, if_pred_taken
  );
endinterface

// File: rtl/stage_if_bpred.sv
// Instruction fetch stage: local IMEM, bimodal 2-bit BHT predictor and the IF/ID register.
module stage_if_bpred #(
  parameter int          IMEM_DEPTH  = 256,
  parameter int          BHT_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [1:0]  BHT_INIT    = 2'b01
) (
  input logic              clk,
  input logic              rst,
  stage_if_bpred_if.master bus
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int BW = $clog2(BHT_ENTRIES);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] imem [IMEM_DEPTH];
  logic [1:0]  bht  [BHT_ENTRIES];

  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] imm_b;
  logic [31:0] pc_4;
  logic [31:0] pc_br;
  logic        is_branch;
  logic        pred;
  logic        bubble;
  logic [IW-1:0] fetch_idx;
  logic [IW-1:0] wr_idx;
  logic [BW-1:0] rd_bidx;
  logic [BW-1:0] up_bidx;
  logic          unused_bits;

  assign fetch_idx = pc[IW+1:2];
  assign wr_idx    = bus.imem_waddr[IW+1:2];
  assign rd_bidx   = pc[BW+1:2];
  assign up_bidx   = bus.bht_upd_pc[BW+1:2];
  assign unused_bits = ^{bus.imem_waddr, bus.bht_upd_pc, pc};

  assign inst      = imem[fetch_idx];
  assign imm_b     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign pc_4      = pc + 32'd4;
  assign pc_br     = pc + imm_b;
  assign is_branch = (inst[6:0] == 7'b1100011);
  assign pred      = is_branch && bht[rd_bidx][1];
  assign bubble    = bus.imem_wren || bus.redirect || bus.jump;

  // IMEM is deliberately outside reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (bus.imem_wren) imem[wr_idx] <= bus.imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_INIT;
    end else if (bus.bht_upd) begin
      if (bus.bht_upd_taken && bht[up_bidx] != 2'b11)
        bht[up_bidx] <= bht[up_bidx] + 2'd1;
      else if (!bus.bht_upd_taken && bht[up_bidx] != 2'b00)
        bht[up_bidx] <= bht[up_bidx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc                 <= RESET_PC;
      bus.if_valid       <= 1'b0;
      bus.if_pc          <= '0;
      bus.if_pc_4        <= '0;
      bus.if_inst        <= NOP;
      bus.if_branch_addr <= '0;
      bus.if_ctrl_branch <= 1'b0;
      bus.if_pred_taken  <= 1'b0;
    end else begin
      if (bus.imem_wren)     pc <= pc;
      else if (bus.redirect) pc <= bus.redirect_addr;
      else if (bus.jump)     pc <= bus.jump_addr;
      else if (!bus.stall)   pc <= pred ? pc_br : pc_4;

      // Bubble leaves the address fields holding stale values; consumers gate on if_valid.
      if (bubble) begin
        bus.if_valid       <= 1'b0;
        bus.if_inst        <= NOP;
        bus.if_ctrl_branch <= 1'b0;
        bus.if_pred_taken  <= 1'b0;
      end else if (!bus.stall) begin
        bus.if_valid       <= 1'b1;
        bus.if_pc          <= pc;
        bus.if_pc_4        <= pc_4;
        bus.if_inst        <= inst;
        bus.if_branch_addr <= pc_br;
        bus.if_ctrl_branch <= is_branch;
        bus.if_pred_taken  <= pred;
      end
    end
  end
endmodule

// File: tb/tb_stage_if_bpred.sv
// Directed bench for stage_if_bpred: load, prediction, BHT saturation, stall, redirect/jump, wrap, reset.
module tb_stage_if_bpred;
  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  stage_if_bpred_if bus ();

  stage_if_bpred dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Program image: word 2 is "beq x0,x0,+16"; every other word is a distinct addi.
  function automatic logic [31:0] wval(input int k);
    return (k == 2) ? 32'h0000_0863 : ((32'(k) << 20) | 32'h0000_0013);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.imem_wren = 0; bus.imem_waddr = 0; bus.imem_wdata = 0;
    bus.stall = 0; bus.redirect = 0; bus.redirect_addr = 0;
    bus.jump = 0; bus.jump_addr = 0;
    bus.bht_upd = 0; bus.bht_upd_pc = 0; bus.bht_upd_taken = 0;
  endtask

  task automatic jump_to(input logic [31:0] a);
    bus.jump = 1; bus.jump_addr = a;
    tick();
    bus.jump = 0;
  endtask

  task automatic bht_pulse(input logic [31:0] a, input logic t, input int n);
    bus.bht_upd = 1; bus.bht_upd_pc = a; bus.bht_upd_taken = t;
    for (int i = 0; i < n; i++) tick();
    bus.bht_upd = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick(); tick();
    tests++; if ({bus.if_valid, bus.if_ctrl_branch, bus.if_pred_taken} !== 3'b000) begin
      failed++; $display("FAIL reset_flags: got %b want 000", {bus.if_valid, bus.if_ctrl_branch, bus.if_pred_taken}); end
    tests++; if (bus.if_inst !== 32'h13) begin
      failed++; $display("FAIL reset_inst: got %h want 00000013", bus.if_inst); end
    tests++; if ({bus.if_pc, bus.if_pc_4, bus.if_branch_addr} !== 96'h0) begin
      failed++; $display("FAIL reset_addr: got %h %h %h want 0", bus.if_pc, bus.if_pc_4, bus.if_branch_addr); end
  endtask

  task automatic test_load();
    int bad = 0;
    rst = 0;
    bus.imem_wren = 1;
    for (int k = 0; k < 80; k++) begin
      bus.imem_waddr = 32'(k) * 4; bus.imem_wdata = wval(k);
      tick();
      if (bus.if_valid !== 1'b0) bad++;
    end
    bus.imem_waddr = 32'h3FC; bus.imem_wdata = wval(255);
    tick();
    bus.imem_wren = 0;
    tests++; if (bad != 0) begin
      failed++; $display("FAIL load_bubble: got %0d valid cycles want 0", bad); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if ({bus.if_valid, bus.if_pc, bus.if_inst} !== {1'b1, 32'(i * 4), wval(i)}) begin
        failed++; $display("FAIL load_seq%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                           i, bus.if_valid, bus.if_pc, bus.if_inst, i * 4, wval(i)); end
      if (i == 2) begin
        tests++; if ({bus.if_ctrl_branch, bus.if_pred_taken, bus.if_branch_addr} !== {2'b10, 32'd24}) begin
          failed++; $display("FAIL branch_nt: got br=%b pred=%b ba=%h want br=1 pred=0 ba=18",
                             bus.if_ctrl_branch, bus.if_pred_taken, bus.if_branch_addr); end
      end
    end
  endtask

  task automatic test_predict();
    bht_pulse(32'h8, 1'b1, 2);
    jump_to(32'h8);
    tests++; if (bus.if_valid !== 1'b0) begin
      failed++; $display("FAIL jump_bubble: got %b want 0", bus.if_valid); end
    tick();
    tests++; if ({bus.if_pc, bus.if_ctrl_branch, bus.if_pred_taken} !== {32'h8, 2'b11}) begin
      failed++; $display("FAIL pred_taken: got pc=%h br=%b pred=%b want pc=8 br=1 pred=1",
                         bus.if_pc, bus.if_ctrl_branch, bus.if_pred_taken); end
    tick();
    tests++; if ({bus.if_pc, bus.if_inst} !== {32'd24, wval(6)}) begin
      failed++; $display("FAIL pred_target: got pc=%h inst=%h want pc=18 inst=%h", bus.if_pc, bus.if_inst, wval(6)); end
  endtask

  task automatic test_saturate();
    // Five more taken then one not-taken: saturating counter ends at 2 (taken).
    bht_pulse(32'h8, 1'b1, 5);
    bht_pulse(32'h8, 1'b0, 1);
    jump_to(32'h8);
    tick();
    tests++; if ({bus.if_pc, bus.if_pred_taken} !== {32'h8, 1'b1}) begin
      failed++; $display("FAIL sat_high: got pc=%h pred=%b want pc=8 pred=1", bus.if_pc, bus.if_pred_taken); end
    // Update the entry in the same cycle it is read: prediction must use the old value.
    jump_to(32'h8);
    bus.bht_upd = 1; bus.bht_upd_pc = 32'h8; bus.bht_upd_taken = 0;
    tick();
    bus.bht_upd = 0;
    tests++; if ({bus.if_pc, bus.if_pred_taken} !== {32'h8, 1'b1}) begin
      failed++; $display("FAIL same_cycle_old: got pc=%h pred=%b want pc=8 pred=1", bus.if_pc, bus.if_pred_taken); end
    jump_to(32'h8);
    tick();
    tests++; if ({bus.if_pc, bus.if_pred_taken} !== {32'h8, 1'b0}) begin
      failed++; $display("FAIL same_cycle_new: got pc=%h pred=%b want pc=8 pred=0", bus.if_pc, bus.if_pred_taken); end
    tick();
    tests++; if (bus.if_pc !== 32'd12) begin
      failed++; $display("FAIL nt_fallthru: got %h want 0000000c", bus.if_pc); end
  endtask

  task automatic test_stall();
    bus.stall = 1;
    bus.bht_upd = 1; bus.bht_upd_pc = 32'h8; bus.bht_upd_taken = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.bht_upd = 0;
      tests++; if ({bus.if_valid, bus.if_pc, bus.if_pc_4, bus.if_inst} !== {1'b1, 32'd12, 32'd16, wval(3)}) begin
        failed++; $display("FAIL stall_hold%0d: got v=%b pc=%h pc4=%h inst=%h want v=1 pc=c pc4=10 inst=%h",
                           i, bus.if_valid, bus.if_pc, bus.if_pc_4, bus.if_inst, wval(3)); end
    end
    bus.stall = 0;
    tick();
    tests++; if (bus.if_pc !== 32'd16) begin
      failed++; $display("FAIL stall_resume0: got %h want 00000010", bus.if_pc); end
    tick();
    tests++; if (bus.if_pc !== 32'd20) begin
      failed++; $display("FAIL stall_resume1: got %h want 00000014", bus.if_pc); end
  endtask

  task automatic test_sat_low();
    jump_to(32'h8);
    tick();
    tests++; if (bus.if_pred_taken !== 1'b1) begin
      failed++; $display("FAIL upd_in_stall: got pred=%b want 1", bus.if_pred_taken); end
    bht_pulse(32'h8, 1'b0, 3);
    bht_pulse(32'h8, 1'b1, 1);
    jump_to(32'h8);
    tick();
    tests++; if ({bus.if_pc, bus.if_pred_taken} !== {32'h8, 1'b0}) begin
      failed++; $display("FAIL sat_low: got pc=%h pred=%b want pc=8 pred=0", bus.if_pc, bus.if_pred_taken); end
  endtask

  task automatic test_redirect();
    bus.stall = 1; bus.redirect = 1; bus.redirect_addr = 32'h40;
    tick();
    bus.stall = 0; bus.redirect = 0;
    tests++; if ({bus.if_valid, bus.if_ctrl_branch, bus.if_pred_taken, bus.if_inst} !== {3'b000, 32'h13}) begin
      failed++; $display("FAIL redirect_bubble: got v=%b br=%b pred=%b inst=%h want 0 0 0 00000013",
                         bus.if_valid, bus.if_ctrl_branch, bus.if_pred_taken, bus.if_inst); end
    tick();
    tests++; if ({bus.if_valid, bus.if_pc, bus.if_inst} !== {1'b1, 32'h40, wval(16)}) begin
      failed++; $display("FAIL redirect_pc: got v=%b pc=%h inst=%h want v=1 pc=40 inst=%h",
                         bus.if_valid, bus.if_pc, bus.if_inst, wval(16)); end
  endtask

  task automatic test_jump_redirect();
    bus.jump = 1; bus.jump_addr = 32'h80; bus.redirect = 1; bus.redirect_addr = 32'h100;
    tick();
    bus.jump = 0; bus.redirect = 0;
    tests++; if (bus.if_valid !== 1'b0) begin
      failed++; $display("FAIL jr_bubble: got %b want 0", bus.if_valid); end
    tick();
    tests++; if ({bus.if_pc, bus.if_inst} !== {32'h100, wval(64)}) begin
      failed++; $display("FAIL jr_priority: got pc=%h inst=%h want pc=100 inst=%h", bus.if_pc, bus.if_inst, wval(64)); end
    tick();
    tests++; if (bus.if_pc !== 32'h104) begin
      failed++; $display("FAIL jr_next: got %h want 00000104", bus.if_pc); end
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFFC);
    tick();
    tests++; if ({bus.if_pc, bus.if_pc_4, bus.if_inst} !== {32'hFFFF_FFFC, 32'h0, wval(255)}) begin
      failed++; $display("FAIL wrap_top: got pc=%h pc4=%h inst=%h want pc=fffffffc pc4=0 inst=%h",
                         bus.if_pc, bus.if_pc_4, bus.if_inst, wval(255)); end
    tick();
    tests++; if ({bus.if_pc, bus.if_inst} !== {32'h0, wval(0)}) begin
      failed++; $display("FAIL wrap_zero: got pc=%h inst=%h want pc=0 inst=%h", bus.if_pc, bus.if_inst, wval(0)); end
  endtask

  task automatic test_wren_priority();
    bus.imem_wren = 1; bus.imem_waddr = 32'h3FC; bus.imem_wdata = wval(255);
    bus.redirect = 1; bus.redirect_addr = 32'h40;
    tick();
    bus.imem_wren = 0; bus.redirect = 0;
    tests++; if (bus.if_valid !== 1'b0) begin
      failed++; $display("FAIL wren_bubble: got %b want 0", bus.if_valid); end
    tick();
    tests++; if (bus.if_pc !== 32'h4) begin
      failed++; $display("FAIL wren_hold: got %h want 00000004", bus.if_pc); end
  endtask

  task automatic test_mid_reset();
    bht_pulse(32'h8, 1'b1, 3);
    jump_to(32'h20);
    rst = 1;
    bus.bht_upd = 1; bus.bht_upd_pc = 32'h8; bus.bht_upd_taken = 1;
    tick();
    rst = 0; bus.bht_upd = 0;
    tests++; if ({bus.if_valid, bus.if_pred_taken, bus.if_ctrl_branch, bus.if_inst, bus.if_pc} !== {3'b000, 32'h13, 32'h0}) begin
      failed++; $display("FAIL midrst_out: got v=%b pred=%b br=%b inst=%h pc=%h want 0 0 0 00000013 0",
                         bus.if_valid, bus.if_pred_taken, bus.if_ctrl_branch, bus.if_inst, bus.if_pc); end
    tick();
    tests++; if ({bus.if_valid, bus.if_pc, bus.if_inst} !== {1'b1, 32'h0, wval(0)}) begin
      failed++; $display("FAIL midrst_pc: got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h",
                         bus.if_valid, bus.if_pc, bus.if_inst, wval(0)); end
    tick(); tick();
    tests++; if ({bus.if_pc, bus.if_inst, bus.if_pred_taken} !== {32'h8, wval(2), 1'b0}) begin
      failed++; $display("FAIL midrst_bht: got pc=%h inst=%h pred=%b want pc=8 inst=%h pred=0",
                         bus.if_pc, bus.if_inst, bus.if_pred_taken, wval(2)); end
    tick();
    tests++; if (bus.if_pc !== 32'd12) begin
      failed++; $display("FAIL midrst_next: got %h want 0000000c", bus.if_pc); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_predict();
    test_saturate();
    test_stall();
    test_sat_low();
    test_redirect();
    test_jump_redirect();
    test_wrap();
    test_wren_priority();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
